rr_seq_detect_sched: RTL and testbench

Round-robin scheduler that time-shares one 4-state serial pattern detector among `NCH` bit-serial requesters. Per-channel detector state is held in a register file. Each granted sample advances only that channel's state through the shared next-state/output function. Detection results are returned tagged with the channel index. The block sits between the serial input front-ends and the event-collection logic, and replaces `NCH` duplicated detector instances.

---
 rtl/seq_detect_pkg.sv | 15 +
 rtl/seq4_step.sv | 28 ++
 rtl/rr_seq_detect_sched.sv | 111 +++++++++++
 tb/tb_rr_seq_detect_sched.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the time-shared 4-state serial pattern detector.
package seq_detect_pkg;

    // Default number of requesting channels.
    localparam int NCH_DEF = 4;

    // Detector state encoding; the numeric values are part of the interface.
    typedef enum logic [1:0] {
        ST_A = 2'b00,
        ST_B = 2'b01,
        ST_C = 2'b10,
        ST_D = 2'b11
    } state_t;

endpackage

// File: rtl/seq4_step.sv
// One step of the 4-state detector: next state and detection flag for one sample.
// Pure combinational; the top time-shares a single instance across all channels.
module seq4_step
    import seq_detect_pkg::*;
(
    input  state_t st_in,
    input  logic   w,
    output state_t st_out,
    output logic   z
);

    // Next-state/output table; z fires only on the D -> B transition.
    always_comb begin
        st_out = ST_A;
        z      = 1'b0;
        unique case (st_in)
            ST_A: st_out = w ? ST_B : ST_A;
            ST_B: st_out = ST_C;
            ST_C: st_out = ST_D;
            ST_D: begin
                st_out = w ? ST_B : ST_A;
                z      = w;
            end
            default: st_out = ST_A;
        endcase
    end

endmodule

// File: rtl/rr_seq_detect_sched.sv
// Round-robin scheduler sharing one seq4_step among NCH bit-serial requesters.
// Per-channel detector state lives in a small register file; results come out
// one clock after the grant, tagged with the channel index.
module rr_seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = 2
) (
    input  logic            clock,
    input  logic            Reset,
    input  logic [NCH-1:0]  req,
    input  logic [NCH-1:0]  w,
    input  logic [NCH-1:0]  clr,
    output logic [NCH-1:0]  gnt,
    output logic            det_valid,
    output logic [CW-1:0]   det_ch,
    output logic            z
);

    logic [NCH-1:0]       elig;
    logic [CW-1:0]        ptr;
    logic [CW-1:0]        cand;
    logic [CW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic [NCH-1:0][1:0]  st;
    state_t               st_sel;
    state_t               st_nxt;
    logic                 w_sel;
    logic                 z_step;

    // Channel index + 1 with wrap at NCH-1, so non-power-of-two NCH never
    // produces an index outside 0..NCH-1.
    function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] i);
        if (int'(i) >= NCH - 1)
            return '0;
        return i + CW'(1);
    endfunction

    // A channel being cleared cannot be served in the same cycle.
    assign elig = req & ~clr;

    // Rotating priority search starting at ptr; first eligible channel wins.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = ptr;
        for (int o = 0; o < NCH; o++) begin
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
            cand = next_idx(cand);
        end
        if (Reset)
            gnt_any = 1'b0;
        if (gnt_any)
            gnt[gnt_idx] = 1'b1;
    end

    // Route the granted channel's state and sample into the shared datapath.
    assign st_sel = state_t'(st[gnt_idx]);
    assign w_sel  = w[gnt_idx];

    seq4_step u_step (
        .st_in  (st_sel),
        .w      (w_sel),
        .st_out (st_nxt),
        .z      (z_step)
    );

    // State register file: clear wins over a grant; only the granted entry moves.
    always_ff @(posedge clock) begin
        if (Reset) begin
            for (int i = 0; i < NCH; i++)
                st[i] <= ST_A;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i])
                    st[i] <= ST_A;
                else if (gnt[i])
                    st[i] <= st_nxt;
            end
        end
    end

    // Priority pointer moves just past the last winner; holds when idle.
    always_ff @(posedge clock) begin
        if (Reset)
            ptr <= '0;
        else if (gnt_any)
            ptr <= next_idx(gnt_idx);
    end

    // Result registers; channel tag and flag hold their last value when idle.
    always_ff @(posedge clock) begin
        if (Reset) begin
            det_valid <= 1'b0;
            det_ch    <= '0;
            z         <= 1'b0;
        end else begin
            det_valid <= gnt_any;
            if (gnt_any) begin
                det_ch <= gnt_idx;
                z      <= z_step;
            end
        end
    end

endmodule

// File: tb/tb_rr_seq_detect_sched.sv
// Directed bench for rr_seq_detect_sched: expected grants are given per step,
// expected results are queued at grant time and checked one clock later.
module tb_rr_seq_detect_sched;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic           clock = 1'b0;
    logic           Reset;
    logic [NCH-1:0] req, w, clr, gnt;
    logic           det_valid;
    logic [CW-1:0]  det_ch;
    logic           z;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic          z;
    } res_t;

    res_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] last_ch  = '0;
    logic          last_z   = 1'b0;

    rr_seq_detect_sched #(.NCH(NCH), .CW(CW)) dut (
        .clock     (clock),
        .Reset     (Reset),
        .req       (req),
        .w         (w),
        .clr       (clr),
        .gnt       (gnt),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .z         (z)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare registered outputs against the head of the scoreboard, or
    // against the idle/hold behaviour when nothing was granted last cycle.
    task automatic check_result(input string tag);
        res_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check({tag, " det_valid"}, det_valid, 1);
            check({tag, " det_ch"}, det_ch, r.ch);
            check({tag, " z"}, z, r.z);
            last_ch = r.ch;
            last_z  = r.z;
        end else begin
            check({tag, " idle det_valid"}, det_valid, 0);
            check({tag, " hold det_ch"}, det_ch, last_ch);
            check({tag, " hold z"}, z, last_z);
        end
    endtask

    // One clock of stimulus with the expected grant and expected z of the sample.
    task automatic step(input logic [NCH-1:0] rq, input logic [NCH-1:0] wv,
                        input logic [NCH-1:0] cl, input logic [NCH-1:0] exp_gnt,
                        input logic exp_z, input string tag);
        res_t r;
        @(negedge clock);
        check_result(tag);
        req = rq;
        w   = wv;
        clr = cl;
        #1;
        check({tag, " gnt"}, gnt, exp_gnt);
        if (exp_gnt != '0) begin
            r.ch = '0;
            for (int i = 0; i < NCH; i++)
                if (exp_gnt[i]) r.ch = CW'(i);
            r.z = exp_z;
            sb.push_back(r);
        end
    endtask

    // One reset edge with rq presented; grant must stay low and nothing is consumed.
    task automatic do_reset(input logic [NCH-1:0] rq, input string tag);
        @(negedge clock);
        check_result(tag);
        Reset = 1'b1;
        req   = rq;
        w     = rq;
        clr   = '0;
        #1;
        check({tag, " gnt in reset"}, gnt, 0);
        @(negedge clock);
        Reset = 1'b0;
        req   = '0;
        w     = '0;
        sb.delete();
        check({tag, " rst det_valid"}, det_valid, 0);
        check({tag, " rst det_ch"}, det_ch, 0);
        check({tag, " rst z"}, z, 0);
        last_ch = '0;
        last_z  = 1'b0;
    endtask

    initial begin
        logic [NCH-1:0] g;
        logic [NCH-1:0] wv;
        Reset = 1'b1;
        req   = '0;
        w     = '0;
        clr   = '0;
        @(negedge clock);
        do_reset('0, "init");

        // Single channel, pattern 1,0,0,1
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, "t1.s0");
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, "t1.s1");
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, "t1.s2");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, "t1.s3");

        // Overlapping detections via D -> B reuse
        do_reset(4'b0001, "t2.rst");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, "t2.s0");
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, "t2.s1");
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, "t2.s2");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, "t2.s3");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, "t2.s4");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, "t2.s5");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, "t2.s6");

        // All channels requesting: rotation, interleaved 1,0,0,1 per channel.
        // In rounds 0 and 3 only the granted channel's w is 1, so a wrong w mux
        // or a state update on a non-granted channel shows up in z.
        do_reset('0, "t3.rst");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NCH; c++) begin
                g  = NCH'(1) << c;
                wv = (r == 0 || r == 3) ? g : NCH'($urandom_range(0, 15));
                step(4'b1111, wv, 4'b0000, g, (r == 3), $sformatf("t3.r%0d.c%0d", r, c));
            end
        end

        // Clear vs request: bring ch2 to C with ptr=2, then clear it while requesting
        do_reset('0, "t4.rst");
        step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, "t4.a");
        step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, "t4.b");
        step(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, "t4.c");
        step(4'b0110, 4'b0000, 4'b0100, 4'b0010, 1'b0, "t4.clr");
        step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, "t4.d");
        step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, "t4.e");
        step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, "t4.f");
        step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, "t4.g");

        // Idle hold: ptr stays at 3 so ch3 beats ch0
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t5.i0");
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t5.i1");
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t5.i2");
        step(4'b1001, 4'b1000, 4'b0000, 4'b1000, 1'b0, "t5.req3");

        // Reset mid-stream after ch1 reaches D; ptr back to 0 so ch1 beats ch2
        do_reset('0, "t6.rst0");
        step(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, "t6.a");
        step(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, "t6.b");
        step(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, "t6.c");
        do_reset(4'b0010, "t6.rst1");
        step(4'b0110, 4'b0110, 4'b0000, 4'b0010, 1'b0, "t6.d");
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t6.e");

        @(negedge clock);
        check_result("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
